// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: decodes the IR opcode and sequences the datapath enables/selects.
// Optional feature macro: ILLEGAL_TRAP_EN (ILLEGAL state becomes absorbing until rst).
module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        LW_WB    = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11,
        ILLEGAL  = 4'd12
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   pc_write_c;
    logic   ir_write_c;
    logic   reg_write_c;
    logic   mem_write_c;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        pc_write_c    = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write_c   = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        unique case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                // IR latch and PC+4 happen only in the cycle memory delivers the word
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    alu_src_b  = 2'b01;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) state_d = MEM_ADDR;
                else if (opcode == OP_RTYPE)            state_d = R_EXEC;
                else if (opcode == OP_BEQ)              state_d = BRANCH;
                else if (opcode == OP_J)                state_d = JUMP;
                else if (opcode == OP_ADDI)             state_d = I_EXEC;
                else                                    state_d = ILLEGAL;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = LW_WB;
            end
            LW_WB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 1'b1;
                state_d     = FETCH;
            end
            MEM_WR: begin
                mem_write_c = 1'b1;
                i_or_d      = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_write_c = 1'b1;
                reg_dst     = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write_c = 1'b1;
                pc_source  = 2'b10;
                state_d    = FETCH;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = I_WB;
            end
            I_WB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            ILLEGAL: begin
                illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                state_d = ILLEGAL;
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
    end

    // Architectural side effects are suppressed for the whole reset cycle
    assign pc_write  = pc_write_c  & ~rst;
    assign ir_write  = ir_write_c  & ~rst;
    assign reg_write = reg_write_c & ~rst;
    assign mem_write = mem_write_c & ~rst;
    assign state     = state_q;

endmodule
